serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor that computes diff = a - b - bin, LSB first, one bit per clock.
- A single registered borrow flip-flop carries the borrow between bit positions.
- Arithmetic counterpart to the team's combinational full adder; used where area matters more than latency, e.g. decrement and compare paths in the control datapath.
- Operands are loaded with a start/busy/done handshake; the result is held until the next operation.

---
 rtl/serial_subtractor.sv | 205 ++++++++++++++++++++
 tb/tb_serial_subtractor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial WIDTH-bit subtractor, diff = a - b - bin, processed
//             LSB first at one bit per clock. A single borrow flip-flop links
//             the bit positions. This unit is for decrement and compare paths
//             where saving area is worth more than latency.
//
//  Ports    : clk    - rising-edge clock
//             rst_n  - asynchronous active-low reset
//             start  - operation request. It is sampled when no bits are in
//                      flight (IDLE, or the edge that leaves DONE).
//             a, b   - minuend and subtrahend. Captured on acceptance.
//             bin    - borrow-in. Captured on acceptance.
//             busy   - high while an operation is in RUN or DONE
//             done   - one-cycle pulse when diff and bout are valid
//             diff   - a - b - bin mod 2^WIDTH. Held until the next DONE.
//             bout   - borrow-out. Set when a < b + bin (unsigned).
//             ovf    - two's-complement overflow of a - b - bin. This port
//                      exists only when SERSUB_OVF_EN is defined.
//
//  Options  : SERSUB_OVF_EN - adds the signed-overflow output and the
//                             operand MSB capture registers it needs.
//
//  Timing   : If start is accepted at edge 0, bits are processed at edges
//             1..WIDTH. done is high between edge WIDTH and edge WIDTH+1.
//             Edge WIDTH+1 can accept the next operation, so the throughput
//             is one result every WIDTH+1 cycles.
//
//  Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8               // legal range 2..32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Count value at the edge that processes the final (MSB) bit.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sa;      // minuend shift register
    logic [WIDTH-1:0] r_sb;      // subtrahend shift register
    logic [WIDTH-1:0] r_res;     // result bits, filled from the MSB end
    logic             r_br;      // running borrow between bit positions
    logic [CNT_W-1:0] r_cnt;     // index of the bit being processed
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_busy;
    logic             r_done;

`ifdef SERSUB_OVF_EN
    logic             r_amsb;    // sign of the captured minuend
    logic             r_bmsb;    // sign of the captured subtrahend
    logic             r_ovf;
`endif

    // ------------------------------------------------------------------------
    // One-bit full subtractor on the current LSBs
    // ------------------------------------------------------------------------
    logic w_d;
    logic w_br_nxt;
    logic w_last;
    logic w_accept;

    assign w_d      = r_sa[0] ^ r_sb[0] ^ r_br;
    assign w_br_nxt = (~r_sa[0] & r_sb[0]) | (~r_sa[0] & r_br) | (r_sb[0] & r_br);
    assign w_last   = (r_cnt == c_CNT_LAST);

    // The edge that leaves DONE has no bits in flight. Letting it also load
    // the next operation is what gives one result every WIDTH+1 cycles when
    // start is held high. A start seen during RUN is dropped, not queued.
    assign w_accept = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));

    // ------------------------------------------------------------------------
    // Control and datapath sequencing
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_RUN;
                    end
                end

                c_ST_RUN: begin
                    r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
                    r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
                    r_res <= {w_d, r_res[WIDTH-1:1]};
                    r_br  <= w_br_nxt;
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (w_last) begin
                        // The final bit completes here. Publish the result
                        // straight from the shift path so that diff is
                        // already valid during the DONE cycle.
                        r_diff  <= {w_d, r_res[WIDTH-1:1]};
                        r_bout  <= w_br_nxt;
                        r_done  <= 1'b1;
                        r_state <= c_ST_DONE;
                    end
                end

                c_ST_DONE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

`ifdef SERSUB_OVF_EN
    // ------------------------------------------------------------------------
    // Signed overflow. It can only happen when the operand signs differ and
    // the result sign differs from the minuend sign. The result MSB is the
    // bit produced at the final edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_amsb <= 1'b0;
            r_bmsb <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_amsb <= a[WIDTH-1];
                r_bmsb <= b[WIDTH-1];
            end
            if ((r_state == c_ST_RUN) && w_last) begin
                r_ovf <= (r_amsb != r_bmsb) && (w_d != r_amsb);
            end
        end
    end

    assign ovf = r_ovf;
`endif

    // ------------------------------------------------------------------------
    // Outputs are driven only from registers
    // ------------------------------------------------------------------------
    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor
//  Purpose  : Scoreboard bench for serial_subtractor (WIDTH=8). The stimulus
//             pushes the expected result and the due cycle of done for each
//             accepted operation. A monitor process pops one entry on every
//             done pulse and compares it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERSUB_OVF_EN
    logic         ovf;
`endif

    serial_subtractor #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERSUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   errors     = 0;
    int   done_count = 0;
    int   issued     = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: one scoreboard entry is consumed per done pulse
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                done_count++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1, expected no pending op (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_time", cyc, e.due);
                    check("diff", int'(diff), int'(e.d));
                    check("bout", int'(bout), int'(e.bo));
`ifdef SERSUB_OVF_EN
                    check("ovf", int'(ovf), int'(e.ov));
`endif
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                checks++;
                errors++;
                $display("FAIL missing_done: got no done, expected one at cycle %0d", sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    // Push the expected result for an operation accepted at edge acc_cyc.
    task automatic expect_op(input int acc_cyc, input logic [W-1:0] ed,
                             input logic eb, input logic eo);
        exp_t e;
        e.d   = ed;
        e.bo  = eb;
        e.ov  = eo;
        e.due = acc_cyc + W;
        sb.push_back(e);
        issued++;
    endtask

    // Wait (bounded) for idle, then present one op for a single cycle.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                         input logic [W-1:0] ed, input logic eb, input logic eo,
                         output int acc_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_wait: got busy=1 after %0d cycles, expected 0", n);
        end
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        start = 1'b0;
        // Scramble the inputs to confirm they were captured.
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        expect_op(acc_cyc, ed, eb, eo);
    endtask

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic z);
        int r;
        r = int'($signed(x)) - int'($signed(y)) - int'(z);
        return (r > 127) || (r < -128);
    endfunction

    initial begin
        int acc;
        int n;
        int bcnt;
        int dc0;
        logic [W-1:0] ra, rb;
        logic         rbin;
        logic [W:0]   rexp;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_diff", int'(diff), 0);
        check("rst_bout", int'(bout), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic op. busy must stay high for 9 sampled cycles.
        issue(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0, acc);
        bcnt = 0; n = 0;
        @(negedge clk);
        while (busy && n < 30) begin
            bcnt++;
            n++;
            @(negedge clk);
        end
        check("busy_cycles", bcnt, W + 1);

        // Wrap-around and borrow cases
        issue(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, acc);
        issue(8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, acc);
        issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, acc);
        issue(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, acc);
        issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, acc);
        issue(8'h3C, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, acc);

        // Back-to-back with start held high. a/b are disturbed during RUN.
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin @(negedge clk); n++; end
        a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        for (int k = 0; k < 3; k++) expect_op(acc + k * (W + 1), 8'h7F, 1'b0, 1'b1);
        for (int t = 1; t <= 3 * (W + 1) - 1; t++) begin
            @(posedge clk);
            #1;
            if (t % (W + 1) == 3) begin a = 8'h33; b = 8'h11; end
            if (t % (W + 1) == 5) begin a = 8'h80; b = 8'h01; end
        end
        start = 1'b0;

        // Reset in the middle of RUN aborts the op
        issue(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0, acc);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        issued -= sb.size();
        sb.delete();
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_diff", int'(diff), 0);
        check("abort_bout", int'(bout), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dc0 = done_count;
        repeat (15) @(negedge clk);
        check("abort_no_done", done_count, dc0);
        issue(8'h09, 8'h09, 1'b0, 8'h00, 1'b0, 1'b0, acc);

        // Random regression against the reference model
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
            rexp = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
            issue(ra, rb, rbin, rexp[W-1:0], rexp[W], ref_ovf(ra, rb, rbin), acc);
        end

        // Drain the scoreboard
        n = 0;
        while (sb.size() > 0 && n < 100) begin @(negedge clk); n++; end
        check("drain", sb.size(), 0);
        repeat (3) @(negedge clk);
        check("done_count", done_count, issued);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
